hazard_ctrl: RTL and testbench

- Pipeline-control counterpart to the `PipReg` stage registers: `PipReg` stores and forwards stage state, and `hazard_ctrl` decides each cycle whether each stage register loads, holds, or is flushed to a bubble.
- It covers:
  - load-use stalls;
  - multi-cycle mult/div occupancy, tracked by an internal FSM and down-counter;
  - taken-branch flushes.
- It also keeps a saturating stall-cycle performance counter.
- It sits beside the IF/ID and ID/EX pipeline registers in the MIPS pipeline.

---
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decides load/hold/flush for PC, IF/ID and ID/EX,
// tracks mult/div occupancy with a two-state FSM, and counts stall cycles.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int REG_BITS   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_is_md,
  input  logic                id_reads_hilo,
  input  logic                ex_mem_read,
  input  logic [REG_BITS-1:0] ex_rt,
  input  logic                ex_branch_taken,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                md_busy,
  output logic                md_done,
  output logic [15:0]         stall_cycles
);

  localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, MD_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   stall_cycles_q, stall_cycles_d;

  logic lu, mdh, stall, accept;

  // Hazard detection; r0 is hardwired zero so a load to it never creates a dependency.
  always_comb begin
    lu = ex_mem_read && (ex_rt != '0) &&
         ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    mdh    = (state_q == MD_RUN) && (cnt_q != '0) && (id_is_md || id_reads_hilo);
    stall  = (lu || mdh) && !ex_branch_taken;
    accept = id_is_md && !stall && !ex_branch_taken;
  end

  // Branch wins over any stall: the stalled ID instruction is wrong-path anyway.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign md_busy      = (state_q == MD_RUN);
  assign md_done      = md_busy && (cnt_q == '0);
  assign stall_cycles = stall_cycles_q;

  // A taken branch never cancels an in-flight op; only accept depends on it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MD_RUN;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (accept) begin
          cnt_d = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != 16'hFFFF))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a
// cycles-remaining reference model.
module tb_hazard_ctrl;
  localparam int LAT = 4;
  localparam int RB  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [RB-1:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo, ex_mem_read, ex_branch_taken;
  logic pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done;
  logic [15:0] stall_cycles;

  hazard_ctrl #(.MD_LATENCY(LAT), .REG_BITS(RB)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  // model: busy cycles still to go (LAT right after accept, 1 in the done cycle)
  int rem = 0;
  int sc  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                        input bit md, input bit hl, input bit mr, input int ert, input bit br);
    id_rs = RB'(rs); id_rt = RB'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_is_md = md; id_reads_hilo = hl; ex_mem_read = mr; ex_rt = RB'(ert);
    ex_branch_taken = br;
  endtask

  task automatic zero_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check all outputs mid-cycle against the model, then advance one edge.
  task automatic cycle();
    bit m_lu, m_mdh, m_stall, m_acc;
    @(negedge clk);
    m_lu = ex_mem_read && ex_rt != 0 &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    m_mdh   = rem > 1 && (id_is_md || id_reads_hilo);
    m_stall = (m_lu || m_mdh) && !ex_branch_taken;
    m_acc   = id_is_md && !m_stall && !ex_branch_taken;
    chk("pc_en",      32'(pc_en),      32'(!m_stall));
    chk("ifid_en",    32'(ifid_en),    32'(!m_stall));
    chk("ifid_flush", 32'(ifid_flush), 32'(ex_branch_taken));
    chk("idex_flush", 32'(idex_flush), 32'(ex_branch_taken || m_stall));
    chk("md_busy",    32'(md_busy),    32'(rem > 0));
    chk("md_done",    32'(md_done),    32'(rem == 1));
    chk("stall_cnt",  32'(stall_cycles), 32'(sc));
    @(posedge clk);
    if (m_stall && sc < 65535) sc++;
    if (m_acc) rem = LAT;
    else if (rem > 0) rem--;
    #1;
  endtask

  task automatic do_reset();
    zero_in();
    rst = 1'b1;
    #2;
    rem = 0; sc = 0;
    chk("rst_pc_en",   32'(pc_en),        32'd1);
    chk("rst_ifid_en", 32'(ifid_en),      32'd1);
    chk("rst_flushes", 32'({ifid_flush, idex_flush}), 32'd0);
    chk("rst_busy",    32'({md_busy, md_done}), 32'd0);
    chk("rst_stall",   32'(stall_cycles), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    zero_in();
    do_reset();

    // load-use on rs
    set_in(5, 0, 1, 0, 0, 0, 1, 5, 0); cycle();
    zero_in(); cycle();
    chk("lu_count", 32'(stall_cycles), 32'd1);
    // load to r0 never stalls
    set_in(0, 0, 1, 0, 0, 0, 1, 0, 0); cycle();
    chk("r0_count", 32'(stall_cycles), 32'd1);
    // load-use on rt
    set_in(1, 7, 0, 1, 0, 0, 1, 7, 0); cycle();
    chk("lu_rt_count", 32'(stall_cycles), 32'd2);

    // mult then dependent mflo
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
    for (int i = 1; i <= LAT; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    end
    zero_in(); cycle();
    chk("mflo_count", 32'(stall_cycles), 32'(LAT - 1));
    chk("mflo_idle",  32'(md_busy), 32'd0);

    // branch overrides load-use
    do_reset();
    set_in(3, 0, 1, 0, 0, 0, 1, 3, 1); cycle();
    chk("br_count", 32'(stall_cycles), 32'd0);

    // back-to-back mult/div, second one issued in the done cycle
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
    zero_in();
    for (int i = 1; i < LAT; i++) cycle();
    chk("b2b_done", 32'(md_done), 32'd1);
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
    zero_in();
    for (int i = 0; i < LAT; i++) begin
      chk("b2b_busy", 32'(md_busy), 32'd1);
      cycle();
    end
    chk("b2b_end", 32'(md_busy), 32'd0);
    chk("b2b_count", 32'(stall_cycles), 32'd0);

    // reset in cycle 2 of a mult/div, with a stall already counted
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  32'(md_busy), 32'd0);
    chk("mid_rst_done",  32'(md_done), 32'd0);
    chk("mid_rst_count", 32'(stall_cycles), 32'd0);
    rem = 0; sc = 0;
    zero_in();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle();

    // random traffic, small register range to provoke matches
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3),
             $urandom_range(0, 7) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
